// File: rtl/vram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// vram_fifo_pkg
// Shared types and defaults for the VRAM write snooper.
//   - det_state_e  : write-detector states (IDLE / ARMED / CAPTURED)
//   - VRAM_DEF_BASE / VRAM_DEF_SIZE_LOG2 : default snooped window (0xB8000, 32 KiB)
//   - vram_entry_t : layout of one queued write {window offset, byte} for the
//                    default window size; the top packs the same fields in the
//                    same order for any configured window size.
// -----------------------------------------------------------------------------
package vram_fifo_pkg;

    localparam logic [19:0] VRAM_DEF_BASE      = 20'hB8000;
    localparam int          VRAM_DEF_SIZE_LOG2 = 15;
    localparam int          VRAM_DATA_W        = 8;

    typedef enum logic [1:0] {
        DET_IDLE     = 2'd0,
        DET_ARMED    = 2'd1,
        DET_CAPTURED = 2'd2
    } det_state_e;

    typedef struct packed {
        logic [VRAM_DEF_SIZE_LOG2-1:0] offset;
        logic [VRAM_DATA_W-1:0]        data;
    } vram_entry_t;

endpackage

// File: rtl/vram_fifo_core.sv
// -----------------------------------------------------------------------------
// vram_fifo_core
// Generic show-ahead synchronous FIFO, single clock, synchronous active-high
// reset.
// Ports:
//   clock, reset   : clock and synchronous reset
//   push           : allocate a new entry with push_data (ignored when full,
//                    unless a pop happens in the same cycle)
//   pop            : remove the head entry (ignored when empty)
//   overwrite      : replace the data of the tail entry with push_data
//                    without changing the level (ignored when empty; the
//                    caller never asserts it together with push)
//   push_data      : data written by push / overwrite
//   head_data      : storage contents at the read pointer (combinational)
//   tail_data      : storage contents of the most recently written entry
//   level          : number of entries held
//   full, empty    : level == depth, level == 0
// -----------------------------------------------------------------------------
module vram_fifo_core #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  overwrite,
    input  logic [WIDTH-1:0]      push_data,
    output logic [WIDTH-1:0]      head_data,
    output logic [WIDTH-1:0]      tail_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEVEL_W-1:0]    level_q, level_d;

    logic                  pop_s;
    logic                  push_s;
    logic                  overwrite_s;
    logic [DEPTH_LOG2-1:0] tail_ptr_s;

    assign empty = (level_q == LEVEL_W'(0));
    assign full  = (level_q == LEVEL_W'(DEPTH));

    // A pop on an empty FIFO is meaningless; a push into a full FIFO only
    // fits when the head leaves in the same cycle.
    assign pop_s       = pop & ~empty;
    assign push_s      = push & (~full | pop_s);
    assign overwrite_s = overwrite & ~empty;

    assign tail_ptr_s = wr_ptr_q - DEPTH_LOG2'(1);
    assign head_data  = mem_q[rd_ptr_q];
    assign tail_data  = mem_q[tail_ptr_s];
    assign level      = level_q;

    // Next-state for storage, pointers and level.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end else if (overwrite_s) begin
            mem_d[tail_ptr_s] = push_data;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage, pointer and level registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_q <= {DEPTH_LOG2{1'b0}};
            wr_ptr_q <= {DEPTH_LOG2{1'b0}};
            level_q  <= {LEVEL_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/vram_write_fifo.sv
// -----------------------------------------------------------------------------
// vram_write_fifo
// Snoops CPU memory writes that fall inside the video RAM window and queues
// each one as {window offset, byte} for the video-memory port.
// Optional build macro: VRAM_WRITE_FIFO_COALESCE_EN -- a capture whose offset
// matches the tail entry rewrites that entry's byte instead of allocating.
// Ports:
//   clock, reset        : CPU clock, synchronous active-high reset
//   enable              : snoop enable (draining continues when low)
//   address             : CPU bus address
//   internal_data_bus   : CPU write data
//   memory_write_n      : active-low memory write strobe
//   vram_address        : head entry offset (0 when empty)
//   vram_data           : head entry byte (0 when empty)
//   vram_valid          : FIFO not empty
//   vram_ready          : consumer takes the head entry this cycle
//   fifo_level          : number of queued entries
//   overflow            : sticky, a capture was dropped
//   overflow_clear      : clears overflow (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module vram_write_fifo
    import vram_fifo_pkg::*;
#(
    parameter int          DEPTH_LOG2       = 4,
    parameter logic [19:0] WINDOW_BASE      = VRAM_DEF_BASE,
    parameter int          WINDOW_SIZE_LOG2 = VRAM_DEF_SIZE_LOG2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [19:0]                 address,
    input  logic [7:0]                  internal_data_bus,
    input  logic                        memory_write_n,
    output logic [WINDOW_SIZE_LOG2-1:0] vram_address,
    output logic [7:0]                  vram_data,
    output logic                        vram_valid,
    input  logic                        vram_ready,
    output logic [DEPTH_LOG2:0]         fifo_level,
    output logic                        overflow,
    input  logic                        overflow_clear
);

    localparam int ENTRY_W = WINDOW_SIZE_LOG2 + VRAM_DATA_W;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;

    det_state_e                  state_q, state_d;
    logic                        overflow_q, overflow_d;

    logic                        hit_s;
    logic                        capture_s;
    logic                        coalesce_s;
    logic                        alloc_s;
    logic                        pop_s;
    logic                        drop_s;
    logic [WINDOW_SIZE_LOG2-1:0] offset_s;
    logic [ENTRY_W-1:0]          push_entry_s;
    logic [ENTRY_W-1:0]          head_entry_s;
    logic [ENTRY_W-1:0]          tail_entry_s;
    logic [LEVEL_W-1:0]          level_s;
    logic                        full_s;
    logic                        empty_s;

    // The window is aligned to its size, so the offset is simply the low bits.
    assign hit_s = enable & ~memory_write_n &
                   (address[19:WINDOW_SIZE_LOG2] == WINDOW_BASE[19:WINDOW_SIZE_LOG2]);
    assign offset_s     = address[WINDOW_SIZE_LOG2-1:0];
    assign push_entry_s = {offset_s, internal_data_bus};

    // Write-detector state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DET_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write-detector next state: a capture needs two consecutive hit samples,
    // then the detector waits for the strobe to rise so one bus cycle yields
    // exactly one capture.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        if (!enable) begin
            state_d = DET_IDLE;
        end else begin
            case (state_q)
                DET_IDLE: begin
                    if (hit_s) begin
                        state_d = DET_ARMED;
                    end else begin
                        state_d = DET_IDLE;
                    end
                end
                DET_ARMED: begin
                    if (hit_s) begin
                        state_d   = DET_CAPTURED;
                        capture_s = 1'b1;
                    end else begin
                        state_d = DET_IDLE;
                    end
                end
                DET_CAPTURED: begin
                    if (memory_write_n) begin
                        state_d = DET_IDLE;
                    end else begin
                        state_d = DET_CAPTURED;
                    end
                end
                default: begin
                    state_d = DET_IDLE;
                end
            endcase
        end
    end

    // Head leaves only when something is actually presented.
    assign pop_s = vram_ready & ~empty_s;

`ifdef VRAM_WRITE_FIFO_COALESCE_EN
    // Merge with the tail entry when offsets match, unless that tail is the
    // single entry leaving this very cycle.
    always_comb begin
        coalesce_s = 1'b0;
        if (capture_s && !empty_s &&
            (tail_entry_s[ENTRY_W-1:VRAM_DATA_W] == offset_s) &&
            !((level_s == LEVEL_W'(1)) && pop_s)) begin
            coalesce_s = 1'b1;
        end else begin
            coalesce_s = 1'b0;
        end
    end
`else
    assign coalesce_s = 1'b0;
    logic unused_tail_s;
    assign unused_tail_s = ^tail_entry_s;
`endif

    assign alloc_s = capture_s & ~coalesce_s;
    assign drop_s  = alloc_s & full_s & ~pop_s;

    vram_fifo_core #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .push       (alloc_s),
        .pop        (pop_s),
        .overwrite  (coalesce_s),
        .push_data  (push_entry_s),
        .head_data  (head_entry_s),
        .tail_data  (tail_entry_s),
        .level      (level_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Sticky overflow next state; a drop beats a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Show-ahead head presentation, forced to zero while empty.
    always_comb begin
        vram_address = {WINDOW_SIZE_LOG2{1'b0}};
        vram_data    = 8'h00;
        if (!empty_s) begin
            vram_address = head_entry_s[ENTRY_W-1:VRAM_DATA_W];
            vram_data    = head_entry_s[VRAM_DATA_W-1:0];
        end else begin
            vram_address = {WINDOW_SIZE_LOG2{1'b0}};
            vram_data    = 8'h00;
        end
    end

    assign vram_valid = ~empty_s;
    assign fifo_level = level_s;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_vram_write_fifo.sv
// Self-checking bench for vram_write_fifo: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_vram_write_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [19:0] address;
    logic [7:0]  internal_data_bus;
    logic        memory_write_n;
    logic [14:0] vram_address;
    logic [7:0]  vram_data;
    logic        vram_valid;
    logic        vram_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        overflow_clear;

    int errors = 0;
    int checks = 0;

`ifdef VRAM_WRITE_FIFO_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    // Reference model state: queue of {offset, data}, detector run tracking.
    logic [22:0] mq[$];
    int          run_m    = 0;
    bit          locked_m = 1'b0;
    bit          ovf_m    = 1'b0;

    vram_write_fifo dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .address           (address),
        .internal_data_bus (internal_data_bus),
        .memory_write_n    (memory_write_n),
        .vram_address      (vram_address),
        .vram_data         (vram_data),
        .vram_valid        (vram_valid),
        .vram_ready        (vram_ready),
        .fifo_level        (fifo_level),
        .overflow          (overflow),
        .overflow_clear    (overflow_clear)
    );

    always #5 clock = ~clock;

    // One bus sample of the reference model, using the inputs held across the edge.
    task automatic model_step();
        bit hit, push, pop, coal, drop;
        logic [22:0] ent;
        if (reset) begin
            mq.delete();
            run_m = 0; locked_m = 1'b0; ovf_m = 1'b0;
            return;
        end
        hit  = enable && !memory_write_n && (address >= 20'hB8000) && (address <= 20'hBFFFF);
        push = 1'b0;
        if (!enable) begin
            run_m = 0; locked_m = 1'b0;
        end else if (locked_m) begin
            if (memory_write_n) locked_m = 1'b0;
        end else if (hit) begin
            run_m++;
            if (run_m == 2) begin
                push = 1'b1; locked_m = 1'b1; run_m = 0;
            end
        end else begin
            run_m = 0;
        end
        ent  = {15'(address - 20'hB8000), internal_data_bus};
        pop  = (mq.size() > 0) && vram_ready;
        coal = COAL && push && (mq.size() > 0) && (mq[mq.size()-1][22:8] == ent[22:8])
               && !((mq.size() == 1) && pop);
        drop = push && !coal && (mq.size() == 16) && !pop;
        if (pop) void'(mq.pop_front());
        if (coal) mq[mq.size()-1] = ent;
        else if (push && !drop) mq.push_back(ent);
        if (drop) ovf_m = 1'b1;
        else if (overflow_clear) ovf_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic bus_write(input logic [19:0] a, input logic [7:0] d, input int nlow);
        address = a; internal_data_bus = d; memory_write_n = 1'b0;
        repeat (nlow) tick();
        memory_write_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; address = 20'h0; internal_data_bus = 8'h00;
        memory_write_n = 1'b1; vram_ready = 1'b0; overflow_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks += 5;
        if (vram_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", vram_valid); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        if (vram_address !== 15'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", vram_address); end
        if (vram_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 0", vram_data); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    endtask

    task automatic test_single_write();
        address = 20'hB8010; internal_data_bus = 8'h5A; memory_write_n = 1'b0;
        tick();
        checks++;
        if (vram_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", vram_valid); end
        tick();
        checks += 4;
        if (vram_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", vram_valid); end
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        if (vram_address !== 15'h0010) begin errors++; $display("FAIL single_addr: got %h want 0010", vram_address); end
        if (vram_data !== 8'h5A) begin errors++; $display("FAIL single_data: got %h want 5a", vram_data); end
        tick();
        memory_write_n = 1'b1;
        tick();
        checks++;
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_one_push: got %0d want 1", fifo_level); end
        vram_ready = 1'b1;
        tick();
        vram_ready = 1'b0;
        checks += 2;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_pop_level: got %0d want 0", fifo_level); end
        if (vram_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %0b want 0", vram_valid); end
    endtask

    task automatic test_window_filter();
        bus_write(20'hB7FFF, 8'h01, 3);
        bus_write(20'hC0000, 8'h02, 3);
        address = 20'hB8000; internal_data_bus = 8'h03; memory_write_n = 1'b1;
        repeat (3) tick();
        checks += 2;
        if (vram_valid !== 1'b0) begin errors++; $display("FAIL filter_valid: got %0b want 0", vram_valid); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL filter_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_glitch();
        bus_write(20'hB8020, 8'h77, 1);
        checks++;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL glitch_level: got %0d want 0", fifo_level); end
        // A fresh write must again need two samples, proving the detector idled.
        address = 20'hB8021; internal_data_bus = 8'h78; memory_write_n = 1'b0;
        tick();
        checks++;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL glitch_rearm: got %0d want 0", fifo_level); end
        tick();
        checks++;
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL glitch_next_push: got %0d want 1", fifo_level); end
        memory_write_n = 1'b1; vram_ready = 1'b1;
        tick();
        vram_ready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 17; i++) bus_write(20'hB8200 + 20'(i), 8'hA0 + 8'(i), 3);
        checks += 4;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL fill_level: got %0d want 16", fifo_level); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %0b want 1", overflow); end
        if (vram_address !== 15'h0200) begin errors++; $display("FAIL fill_head_addr: got %h want 0200", vram_address); end
        if (vram_data !== 8'hA0) begin errors++; $display("FAIL fill_head_data: got %h want a0", vram_data); end
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
        vram_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (vram_address !== 15'h0200 + 15'(i)) begin errors++; $display("FAIL drain_addr[%0d]: got %h want %h", i, vram_address, 15'h0200 + 15'(i)); end
            if (vram_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, vram_data, 8'hA0 + 8'(i)); end
            tick();
        end
        vram_ready = 1'b0;
        checks += 2;
        if (vram_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b want 0", vram_valid); end
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) bus_write(20'hB8300 + 20'(i), 8'h30 + 8'(i), 3);
        address = 20'hB8310; internal_data_bus = 8'hEE; memory_write_n = 1'b0;
        tick();
        vram_ready = 1'b1;
        tick();
        vram_ready = 1'b0;
        checks += 3;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL fullpp_level: got %0d want 16", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf: got %0b want 0", overflow); end
        if (vram_address !== 15'h0301) begin errors++; $display("FAIL fullpp_head: got %h want 0301", vram_address); end
        memory_write_n = 1'b1;
        tick();
        vram_ready = 1'b1;
        repeat (15) tick();
        vram_ready = 1'b0;
        checks += 3;
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL fullpp_last_level: got %0d want 1", fifo_level); end
        if (vram_address !== 15'h0310) begin errors++; $display("FAIL fullpp_last_addr: got %h want 0310", vram_address); end
        if (vram_data !== 8'hEE) begin errors++; $display("FAIL fullpp_last_data: got %h want ee", vram_data); end
        vram_ready = 1'b1;
        tick();
        vram_ready = 1'b0;
    endtask

    task automatic test_coalesce();
        bus_write(20'hB8100, 8'h11, 3);
        bus_write(20'hB8100, 8'h22, 3);
        checks += 2;
        if (fifo_level !== (COAL ? 5'd1 : 5'd2)) begin errors++; $display("FAIL coalesce_level: got %0d want %0d", fifo_level, COAL ? 1 : 2); end
        if (vram_data !== (COAL ? 8'h22 : 8'h11)) begin errors++; $display("FAIL coalesce_head: got %h want %h", vram_data, COAL ? 8'h22 : 8'h11); end
        vram_ready = 1'b1;
        repeat (2) tick();
        vram_ready = 1'b0;
        checks++;
        if (vram_valid !== 1'b0) begin errors++; $display("FAIL coalesce_drain: got %0b want 0", vram_valid); end
    endtask

    task automatic test_random();
        logic [19:0] addrs [7];
        logic [22:0] exp_head;
        bit          exp_valid;
        addrs[0] = 20'hB8000; addrs[1] = 20'hB8001; addrs[2] = 20'hB8002; addrs[3] = 20'hBFFFF;
        addrs[4] = 20'hB8003; addrs[5] = 20'hB7FFF; addrs[6] = 20'hC0000;
        for (int n = 0; n < 600; n++) begin
            reset             = (n == 300);
            enable            = ($urandom_range(0, 19) != 0);
            memory_write_n    = ($urandom_range(0, 9) < 3);
            address           = addrs[$urandom_range(0, 6)];
            internal_data_bus = 8'($urandom);
            vram_ready        = ($urandom_range(0, 3) == 0);
            overflow_clear    = ($urandom_range(0, 19) == 0);
            tick();
            exp_valid = (mq.size() > 0);
            exp_head  = exp_valid ? mq[0] : 23'd0;
            checks += 5;
            if (vram_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, vram_valid, exp_valid); end
            if (fifo_level !== 5'(mq.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, fifo_level, mq.size()); end
            if (vram_address !== exp_head[22:8]) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", n, vram_address, exp_head[22:8]); end
            if (vram_data !== exp_head[7:0]) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, vram_data, exp_head[7:0]); end
            if (overflow !== ovf_m) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, overflow, ovf_m); end
        end
        reset = 1'b0; enable = 1'b1; memory_write_n = 1'b1;
        vram_ready = 1'b0; overflow_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_window_filter();
        test_glitch();
        test_fill_overflow();
        test_full_push_pop();
        test_coalesce();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
